// File: rtl/freq_spectrum_smoother.sv
// Per-bin exponential smoother for the FFT power stream.
// Locks onto frame boundaries and keeps a 1024x8 history of smoothed values.
// Writes each smoothed bin to the display buffer two cycles after the sample.
// Reports the peak bin of every completed, unfrozen frame.
module freq_spectrum_smoother #(
    parameter int NUM_BINS = 1024,
    parameter int ADDR_W   = 10
) (
    input  logic              ckFreq,
    input  logic              aresetn,
    input  logic              flgFreqSampleValid,
    input  logic [ADDR_W-1:0] addrFreq,
    input  logic [7:0]        byteFreqSample,
    input  logic [1:0]        avgShift,
    input  logic              flgFreeze,
    input  logic              flgClear,
    output logic              weDisp,
    output logic [ADDR_W-1:0] addrDisp,
    output logic [7:0]        dinDisp,
    output logic              flgPeakValid,
    output logic [ADDR_W-1:0] addrPeak,
    output logic [7:0]        bytePeak,
    output logic              flgFrameErr
);
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(NUM_BINS - 1);

    typedef enum logic {ST_WAIT_SYNC, ST_RUN} state_t;

    logic [1:0]        rst_pipe;
    logic              rst_n;
    state_t            state, state_next;
    logic [ADDR_W-1:0] expected;
    logic              clear_pending, freeze_latched, use_raw;
    logic              in_run, is_zero, accept, mismatch, frame_start;

    logic [7:0]        mem [NUM_BINS];
    logic [7:0]        ram_q;

    logic              s1_vld, s1_first, s1_last;
    logic [ADDR_W-1:0] s1_addr;
    logic [7:0]        s1_new;
    logic [1:0]        s1_shift;

    logic signed [8:0] diff;
    logic [7:0]        step, avg;
    logic              wr_en, take_new;
    logic [ADDR_W-1:0] cur_addr, pk_addr;
    logic [7:0]        cur_val, pk_val;

    // Reset asserts immediately, releases two ckFreq edges later
    always_ff @(posedge ckFreq or negedge aresetn) begin
        if (!aresetn) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    // Frame-sync decode of the incoming sample
    always_comb begin
        in_run      = (state == ST_RUN);
        is_zero     = (addrFreq == '0);
        accept      = flgFreqSampleValid && (is_zero || (in_run && addrFreq == expected));
        mismatch    = flgFreqSampleValid && in_run && (addrFreq != expected);
        frame_start = accept && is_zero;
    end

    // Next state: any accepted sample keeps/enters run, a discarded mismatch drops sync
    always_comb begin
        state_next = state;
        if (accept)        state_next = ST_RUN;
        else if (mismatch) state_next = ST_WAIT_SYNC;
    end

    // State register, expected-address counter and per-frame mode latches
    always_ff @(posedge ckFreq or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_WAIT_SYNC;
            expected       <= '0;
            clear_pending  <= 1'b1;
            freeze_latched <= 1'b0;
            use_raw        <= 1'b0;
        end else begin
            state <= state_next;
            if (accept)
                expected <= (addrFreq == LAST_BIN) ? '0 : addrFreq + ADDR_W'(1);
            // A clear that lands on a frame start is kept for the following frame
            if (frame_start) begin
                freeze_latched <= flgFreeze;
                use_raw        <= clear_pending;
                clear_pending  <= flgClear;
            end else if (flgClear) begin
                clear_pending <= 1'b1;
            end
        end
    end

    // History RAM: read on accept, write back the smoothed value a cycle later
    always_ff @(posedge ckFreq) begin
        if (accept) ram_q <= mem[addrFreq];
        if (wr_en)  mem[s1_addr] <= avg;
    end

    // Stage 1 carries the sample alongside the RAM read
    always_ff @(posedge ckFreq or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_addr  <= '0;
            s1_new   <= '0;
            s1_shift <= '0;
        end else begin
            s1_vld   <= accept;
            s1_first <= frame_start;
            s1_last  <= (addrFreq == LAST_BIN);
            s1_addr  <= addrFreq;
            s1_new   <= byteFreqSample;
            s1_shift <= avgShift;
        end
    end

    // Smoothing: old + floor((new-old)/2^s); result stays within [old,new] so 8 bits suffice
    always_comb begin
        diff     = $signed({1'b0, s1_new}) - $signed({1'b0, ram_q});
        step     = 8'(diff >>> s1_shift);
        avg      = (use_raw || s1_shift == 2'd0) ? s1_new : ram_q + step;
        wr_en    = s1_vld && !freeze_latched;
        take_new = s1_first || (avg > cur_val);
        pk_addr  = take_new ? s1_addr : cur_addr;
        pk_val   = take_new ? avg : cur_val;
    end

    // Running peak of the current frame; strict > keeps the lowest bin on ties
    always_ff @(posedge ckFreq or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr <= '0;
            cur_val  <= '0;
        end else if (mismatch) begin
            cur_addr <= '0;
            cur_val  <= '0;
        end else if (s1_vld) begin
            cur_addr <= pk_addr;
            cur_val  <= pk_val;
        end
    end

    // Registered display, peak and error outputs
    always_ff @(posedge ckFreq or negedge rst_n) begin
        if (!rst_n) begin
            weDisp       <= 1'b0;
            addrDisp     <= '0;
            dinDisp      <= '0;
            flgPeakValid <= 1'b0;
            addrPeak     <= '0;
            bytePeak     <= '0;
            flgFrameErr  <= 1'b0;
        end else begin
            weDisp       <= wr_en;
            flgPeakValid <= wr_en && s1_last;
            flgFrameErr  <= mismatch;
            if (wr_en) begin
                addrDisp <= s1_addr;
                dinDisp  <= avg;
            end
            if (wr_en && s1_last) begin
                addrPeak <= pk_addr;
                bytePeak <= pk_val;
            end
        end
    end
endmodule
